// File: rtl/ila_readout_pkg.sv
// Shared types and constants for the ILA readout engine and its serializer.
package ila_readout_pkg;

  // Upper half of header word 0 ("IL" in ASCII).
  localparam logic [15:0] ILA_READOUT_MAGIC = 16'h494C;

  // Width of one transport word.
  localparam int ILA_READOUT_WORD_BITS = 32;

  // Readout FSM states. ST_HEADER is only reachable when the header is built in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_FETCH,
    ST_WAIT,
    ST_SHIFT
  } ila_readout_state_t;

  // Number of transport words needed to carry one sample of the given width.
  function automatic int words_for_width(input int width);
    return (width + ILA_READOUT_WORD_BITS - 1) / ILA_READOUT_WORD_BITS;
  endfunction

endpackage

// File: rtl/ila_readout_engine_serializer.sv
// ila_word_serializer: takes one TOTAL_WIDTH-bit sample and presents it as
// consecutive 32-bit words (least significant word first) on a valid/ready
// stream. Bits above TOTAL_WIDTH in the last word read as zero. empty_o is
// high whenever no word is pending.
module ila_word_serializer
  import ila_readout_pkg::*;
#(
  parameter int TOTAL_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   load_i,
  input  logic [TOTAL_WIDTH-1:0] sample_i,
  input  logic                   last_sample_i,
  input  logic                   ready_i,
  output logic                   valid_o,
  output logic [31:0]            data_o,
  output logic                   last_o,
  output logic                   last_word_o,
  output logic                   empty_o
);

  localparam int WORDS    = words_for_width(TOTAL_WIDTH);
  localparam int PAD_W    = WORDS * ILA_READOUT_WORD_BITS;
  localparam int IDX_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(WORDS - 1);

  logic [PAD_W-1:0]    shreg_q;
  logic [PAD_W-1:0]    shreg_d;
  logic [IDX_BITS-1:0] idx_q;
  logic [IDX_BITS-1:0] idx_d;
  logic                valid_q;
  logic                last_sample_q;
  logic                fire;

  assign fire    = valid_q && ready_i;
  assign shreg_d = shreg_q >> ILA_READOUT_WORD_BITS;
  assign idx_d   = idx_q + 1'b1;

  // Load a sample, then shift one word out per handshake; clear drops the word.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q       <= '0;
      idx_q         <= '0;
      valid_q       <= 1'b0;
      last_sample_q <= 1'b0;
    end else if (clear_i) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      shreg_q       <= PAD_W'(sample_i);
      idx_q         <= '0;
      valid_q       <= 1'b1;
      last_sample_q <= last_sample_i;
    end else if (fire) begin
      shreg_q <= shreg_d;
      if (idx_q == LAST_IDX) begin
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_d;
      end
    end
  end

  assign valid_o     = valid_q;
  assign data_o      = shreg_q[31:0];
  assign last_word_o = (idx_q == LAST_IDX);
  assign last_o      = valid_q && last_sample_q && (idx_q == LAST_IDX);
  assign empty_o     = !valid_q;

endmodule

// File: rtl/ila_readout_engine.sv
// ila_readout_engine: after a capture, walks the capture buffer from base_ptr
// through all DEPTH samples (wrapping) and streams each sample as 32-bit words.
// Optional build macro: ILA_READOUT_HEADER_EN prepends two header words
// ({magic, TOTAL_WIDTH[15:0]} then DEPTH) to the stream.
module ila_readout_engine
  import ila_readout_pkg::*;
#(
  parameter  int TOTAL_WIDTH = 32,
  parameter  int DEPTH       = 1024,
  localparam int ADDR_BITS   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_BITS-1:0]   base_ptr,
  output logic                   busy,
  output logic                   done,
  output logic                   buf_rd_en,
  output logic [ADDR_BITS-1:0]   buf_rd_addr,
  input  logic [TOTAL_WIDTH-1:0] buf_rd_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [31:0]            dout_data,
  output logic                   dout_last
);

  localparam int CNT_BITS = ADDR_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEPTH - 1);

  ila_readout_state_t   state_q;
  logic [ADDR_BITS-1:0] rd_ptr_q;
  logic [ADDR_BITS-1:0] rd_ptr_d;
  logic [CNT_BITS-1:0]  count_q;
  logic [CNT_BITS-1:0]  count_d;
  logic                 busy_q;
  logic                 done_q;
  logic                 buf_rd_en_q;
  logic [ADDR_BITS-1:0] buf_rd_addr_q;

  logic        ser_load;
  logic        ser_valid;
  logic [31:0] ser_data;
  logic        ser_last;
  logic        ser_last_word;
  logic        ser_empty;
  logic        ser_fire;

`ifdef ILA_READOUT_HEADER_EN
  logic        hdr_valid_q;
  logic        hdr_idx_q;
  logic [31:0] hdr_word;

  assign hdr_word = hdr_idx_q ? 32'(DEPTH) : {ILA_READOUT_MAGIC, 16'(TOTAL_WIDTH)};
`endif

  // Pointer wraps modulo DEPTH through natural overflow of ADDR_BITS.
  assign rd_ptr_d = rd_ptr_q + 1'b1;
  assign count_d  = count_q + 1'b1;
  assign ser_load = (state_q == ST_WAIT) && !abort;
  assign ser_fire = ser_valid && dout_ready;

  ila_word_serializer #(
    .TOTAL_WIDTH (TOTAL_WIDTH)
  ) u_serializer (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (abort),
    .load_i        (ser_load),
    .sample_i      (buf_rd_data),
    .last_sample_i (count_q == CNT_LAST),
    .ready_i       (dout_ready),
    .valid_o       (ser_valid),
    .data_o        (ser_data),
    .last_o        (ser_last),
    .last_word_o   (ser_last_word),
    .empty_o       (ser_empty)
  );

  // Readout FSM with registered busy/done/read-port outputs; abort wins over all.
  // NOTE: done_q and buf_rd_en_q default low at the top of the clocked block so
  // they form single-cycle pulses; defaults in a clocked block never infer latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      buf_rd_en_q   <= 1'b0;
      buf_rd_addr_q <= '0;
`ifdef ILA_READOUT_HEADER_EN
      hdr_valid_q   <= 1'b0;
      hdr_idx_q     <= 1'b0;
`endif
    end else begin
      done_q      <= 1'b0;
      buf_rd_en_q <= 1'b0;
      if (abort && state_q != ST_IDLE) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
`ifdef ILA_READOUT_HEADER_EN
        hdr_valid_q <= 1'b0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start && !abort && ser_empty) begin
              rd_ptr_q <= base_ptr;
              count_q  <= '0;
              busy_q   <= 1'b1;
`ifdef ILA_READOUT_HEADER_EN
              state_q     <= ST_HEADER;
              hdr_valid_q <= 1'b1;
              hdr_idx_q   <= 1'b0;
`else
              state_q       <= ST_FETCH;
              buf_rd_en_q   <= 1'b1;
              buf_rd_addr_q <= base_ptr;
`endif
            end
          end
`ifdef ILA_READOUT_HEADER_EN
          ST_HEADER: begin
            if (dout_ready) begin
              if (hdr_idx_q) begin
                hdr_valid_q   <= 1'b0;
                state_q       <= ST_FETCH;
                buf_rd_en_q   <= 1'b1;
                buf_rd_addr_q <= rd_ptr_q;
              end else begin
                hdr_idx_q <= 1'b1;
              end
            end
          end
`endif
          ST_FETCH: state_q <= ST_WAIT;
          ST_WAIT:  state_q <= ST_SHIFT;
          ST_SHIFT: begin
            if (ser_fire && ser_last_word) begin
              rd_ptr_q <= rd_ptr_d;
              count_q  <= count_d;
              if (count_d == CNT_FULL) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q       <= ST_FETCH;
                buf_rd_en_q   <= 1'b1;
                buf_rd_addr_q <= rd_ptr_d;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign buf_rd_en   = buf_rd_en_q;
  assign buf_rd_addr = buf_rd_addr_q;
  assign dout_last   = ser_last;

`ifdef ILA_READOUT_HEADER_EN
  assign dout_valid = hdr_valid_q | ser_valid;
  assign dout_data  = hdr_valid_q ? hdr_word : ser_data;
`else
  assign dout_valid = ser_valid;
  assign dout_data  = ser_data;
`endif

endmodule

// File: tb/tb_ila_readout_engine.sv
// Bench for ila_readout_engine: two instances (32-bit x 8 and 40-bit x 4),
// a word-queue reference model with a per-cycle compare process, and
// directed scenarios with literal expectations. Honours ILA_READOUT_HEADER_EN.
module tb_ila_readout_engine;

`ifdef ILA_READOUT_HEADER_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort, sel, rand_ready, rnd_bit, check_en;
  logic [2:0] base;
  logic       ready;

  assign ready = rand_ready ? rnd_bit : 1'b1;

  // Instance A: 32-bit samples, depth 8, buffer[i] = i.
  logic        a_busy, a_done, a_rd_en, a_valid, a_last;
  logic [2:0]  a_rd_addr;
  logic [31:0] a_rd_data, a_data;
  // Instance B: 40-bit samples, depth 4, buffer[i] = 40'hAB_0000_0000 + i.
  logic        b_busy, b_done, b_rd_en, b_valid, b_last;
  logic [1:0]  b_rd_addr;
  logic [39:0] b_rd_data;
  logic [31:0] b_data;

  ila_readout_engine #(.TOTAL_WIDTH(32), .DEPTH(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
    .base_ptr(base), .busy(a_busy), .done(a_done), .buf_rd_en(a_rd_en),
    .buf_rd_addr(a_rd_addr), .buf_rd_data(a_rd_data), .dout_valid(a_valid),
    .dout_ready(ready), .dout_data(a_data), .dout_last(a_last)
  );

  ila_readout_engine #(.TOTAL_WIDTH(40), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
    .base_ptr(base[1:0]), .busy(b_busy), .done(b_done), .buf_rd_en(b_rd_en),
    .buf_rd_addr(b_rd_addr), .buf_rd_data(b_rd_data), .dout_valid(b_valid),
    .dout_ready(ready), .dout_data(b_data), .dout_last(b_last)
  );

  // Capture buffer models: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= 32'(a_rd_addr);
    if (b_rd_en) b_rd_data <= 40'hAB_0000_0000 + 40'(b_rd_addr);
  end

  // Outputs of the instance under test.
  logic        m_busy, m_done, m_rd_en, m_valid, m_last;
  logic [2:0]  m_rd_addr;
  logic [31:0] m_data;
  assign m_busy    = sel ? b_busy    : a_busy;
  assign m_done    = sel ? b_done    : a_done;
  assign m_rd_en   = sel ? b_rd_en   : a_rd_en;
  assign m_rd_addr = sel ? {1'b0, b_rd_addr} : a_rd_addr;
  assign m_valid   = sel ? b_valid   : a_valid;
  assign m_data    = sel ? b_data    : a_data;
  assign m_last    = sel ? b_last    : a_last;

  // Random ready, changed just after each rising edge.
  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          exp_idx;
  bit          active, exp_done, stalled;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [63:0] smp;
  int          m_tw, m_depth, m_wps;

  // Whole readout as a list of words, built from the buffer contents.
  task automatic build_expected();
    m_tw    = sel ? 40 : 32;
    m_depth = sel ? 4 : 8;
    m_wps   = sel ? 2 : 1;
    exp_q.delete();
`ifdef ILA_READOUT_HEADER_EN
    exp_q.push_back({16'h494C, 16'(m_tw)});
    exp_q.push_back(32'(m_depth));
`endif
    for (int k = 0; k < m_depth; k++) begin
      int addr;
      addr = (int'(base) % m_depth + k) % m_depth;
      smp  = sel ? (64'hAB_0000_0000 + 64'(addr)) : 64'(addr);
      for (int w = 0; w < m_wps; w++) exp_q.push_back(smp[32*w +: 32]);
    end
  endtask

  // Compare process: checks outputs every cycle, then advances the model for the next edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("done", 32'(m_done), 32'(exp_done));
      check("busy", 32'(m_busy), 32'(active));
      if (!active) begin
        check("valid while idle", 32'(m_valid), 32'd0);
      end else begin
        if (stalled) check("valid held", 32'(m_valid), 32'd1);
        if (m_valid) begin
          check("data", m_data, (exp_idx < exp_q.size()) ? exp_q[exp_idx] : 32'hDEAD_BEEF);
          check("last", 32'(m_last), 32'(exp_idx == exp_q.size() - 1));
          if (stalled) begin
            check("data stable", m_data, prev_data);
            check("last stable", 32'(m_last), 32'(prev_last));
          end
        end
      end
      exp_done = 1'b0;
      stalled  = 1'b0;
      if (rst) begin
        active = 1'b0;
      end else if (active) begin
        if (abort) begin
          active = 1'b0;
        end else if (m_valid && ready) begin
          got_q.push_back(m_data);
          exp_idx++;
          if (exp_idx == exp_q.size()) begin
            active   = 1'b0;
            exp_done = 1'b1;
          end
        end else if (m_valid) begin
          stalled   = 1'b1;
          prev_data = m_data;
          prev_last = m_last;
        end
      end else if (start && !abort) begin
        build_expected();
        got_q.delete();
        exp_idx = 0;
        active  = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int t_first, t_done, t_rden;

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},  32'(m_busy),    32'd0);
    check({tag, " done"},  32'(m_done),    32'd0);
    check({tag, " rd_en"}, 32'(m_rd_en),   32'd0);
    check({tag, " rd_addr"}, 32'(m_rd_addr), 32'd0);
    check({tag, " valid"}, 32'(m_valid),   32'd0);
    check({tag, " data"},  m_data,         32'd0);
    check({tag, " last"},  32'(m_last),    32'd0);
  endtask

  // Pulse start (called just after a rising edge) and run until done, bounded.
  task automatic run_readout(input logic [2:0] b);
    base    = b;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    t_first = -1;
    t_done  = -1;
    t_rden  = -1;
    for (int n = 1; n < 2000 && t_done < 0; n++) begin
      @(negedge clk);
      if (m_rd_en && t_rden < 0) t_rden = n;
      if (m_valid && t_first < 0) t_first = n;
      if (m_done) t_done = n;
      @(posedge clk);
      #1;
    end
    check("done reached", 32'(t_done >= 0), 32'd1);
  endtask

  logic [31:0] lit_a[8];
  logic [31:0] lit_b[8];
  bit          found;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; base = '0; sel = 1'b0;
    rand_ready = 1'b0; check_en = 1'b0; active = 1'b0; exp_done = 1'b0;
    stalled = 1'b0; exp_idx = 0;
    lit_a = '{32'd5, 32'd6, 32'd7, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    lit_b = '{32'd0, 32'hAB, 32'd1, 32'hAB, 32'd2, 32'hAB, 32'd3, 32'hAB};

    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; #1 check_reset_outputs("reset A");
    sel = 1'b1; #1 check_reset_outputs("reset B");
    sel = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;

    // 32-bit x 8, base 5, ready held high.
    sel = 1'b0;
    run_readout(3'd5);
    check("A rd_en cycle", 32'(t_rden), 32'(1 + HDR));
    check("A first valid cycle", 32'(t_first), (HDR > 0) ? 32'd1 : 32'd3);
    check("A done cycle", 32'(t_done), 32'(8 * 3 + 1 + HDR));
    check("A word count", 32'(got_q.size()), 32'(8 + HDR));
    for (int i = 0; i < 8; i++) check("A literal word", got_q[HDR + i], lit_a[i]);

    // 40-bit x 4, base 0, ready held high.
    sel = 1'b1;
    run_readout(3'd0);
    check("B done cycle", 32'(t_done), 32'(4 * 4 + 1 + HDR));
    check("B word count", 32'(got_q.size()), 32'(8 + HDR));
    for (int i = 0; i < 8; i++) check("B literal word", got_q[HDR + i], lit_b[i]);
`ifdef ILA_READOUT_HEADER_EN
    check("B header 0", got_q[0], 32'h494C_0028);
    check("B header 1", got_q[1], 32'h0000_0004);
`endif

    // Random backpressure on both instances.
    rand_ready = 1'b1;
    run_readout(3'd2);
    check("B rand word count", 32'(got_q.size()), 32'(8 + HDR));
    check("B rand first word", got_q[HDR], 32'd2);
    sel = 1'b0;
    run_readout(3'd3);
    check("A rand word count", 32'(got_q.size()), 32'(8 + HDR));
    check("A rand last word", got_q[HDR + 7], 32'd2);
    rand_ready = 1'b0;

    // Abort while the third data word is on the bus with ready high.
    base  = 3'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (m_valid && got_q.size() == HDR + 2) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("abort reached third word", 32'(found), 32'd1);
    check("abort third word value", m_data, 32'd3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort valid", 32'(m_valid), 32'd0);
    check("abort busy", 32'(m_busy), 32'd0);
    check("abort done", 32'(m_done), 32'd0);
    check("abort words accepted", 32'(got_q.size()), 32'(HDR + 2));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    run_readout(3'd6);
    check("restart first word", got_q[HDR], 32'd6);
    check("restart last word", got_q[HDR + 7], 32'd5);
    check("restart done cycle", 32'(t_done), 32'(8 * 3 + 1 + HDR));

    // Start while busy is ignored; rst mid-SHIFT returns outputs to reset values.
    sel   = 1'b1;
    base  = 3'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    base  = 3'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (m_valid && got_q.size() >= HDR) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("shift reached", 32'(found), 32'd1);
    check("busy start ignored", m_data, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after rst");
    @(posedge clk);
    #1;
    run_readout(3'd1);
    check("post-rst first word", got_q[HDR], 32'd1);
    check("post-rst second word", got_q[HDR + 1], 32'hAB);
    check("post-rst done cycle", 32'(t_done), 32'(4 * 4 + 1 + HDR));

    repeat (2) @(posedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
